alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
//  Shares the single 8-bit ALU (FWD/ADD/AND/OR, opcodes 000..011) between two requesters, A and B.
//  Accepts one operation at a time over a valid/ready handshake and drives the ALU operand/opcode inputs from registers.
//  Waits WAIT_CYC clocks for the ALU's propagation delay to settle, then captures result and ZERO.
//  Returns them to the originating requester with a one-cycle response strobe; arbitration is round-robin.
// PARAMETERS
//  W        8  operand/result width; must match the ALU width
//  WAIT_CYC 1  clocks between operand issue and result capture; >=1
// PORTS
//  clk        in  1     system clock, rising edge
//  reset_n    in  1     asynchronous active-low reset
//  a_valid    in  1     requester A presents an operation
//  a_ready    out 1     A's operation is accepted at this edge (combinational)
//  a_data1    in  W     A operand 1
//  a_data2    in  W     A operand 2
//  a_op       in  3     A opcode
//  a_rvalid   out 1     one-cycle strobe: a_result/a_zero/a_err are valid
//  a_result   out W     result of A's last operation; held until A's next response
//  a_zero     out 1     ALU ZERO captured for A's last operation
//  a_err      out 1     A's last operation had an illegal opcode
//  b_*        --  --    same nine ports as a_*, for requester B
//  alu_data1  out W     to ALU data1, registered
//  alu_data2  out W     to ALU data2, registered
//  alu_op     out 3     to ALU operation, registered
//  alu_result in  W     from ALU result
//  alu_zero   in  1     from ALU ZERO
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - state=IDLE; all outputs 0, including alu_* registers and every response register.
//   - last-served pointer = B, so A wins the first tie.
//   - Asserting reset mid-operation abandons the operation; no rvalid is ever issued for it.
//  States: IDLE, EXEC, RESP.
//  IDLE:
//   - grant = A if a_valid and (!b_valid or last==B); B if b_valid and (!a_valid or last==A).
//   - x_ready = (state==IDLE) && grant==x; only one ready is high at a time; ready is never high outside IDLE.
//   - Accept edge T0 (x_valid && x_ready) with a legal op (op[2]==0):
//     - alu_data1/alu_data2/alu_op <= x operands; owner <= x; last <= x; cnt <= WAIT_CYC-1; go to EXEC.
//   - Accept with an illegal op (op[2]==1):
//     - alu_* are unchanged; owner <= x; last <= x; go directly to RESP.
//     - The response is result=0, zero=0, err=1, with rvalid in the cycle after T0.
//  EXEC:
//   - cnt!=0: decrement cnt.
//   - cnt==0: capture owner's x_result <= alu_result, x_zero <= alu_zero, x_err <= 0; go to RESP.
//   - With WAIT_CYC=1, capture happens at edge T0+1.
//  RESP:
//   - Owner's x_rvalid=1 for exactly this one cycle; unconditionally return to IDLE.
//   - There is no response backpressure.
//  Timing:
//   - Legal op: rvalid is high in cycle [T0+WAIT_CYC, T0+WAIT_CYC+1).
//   - Earliest next accept is edge T0+WAIT_CYC+1.
//  Other rules:
//   - alu_* hold their last values between operations; the ALU output is never sampled outside EXEC with cnt==0.
//   - x_zero is the ALU ZERO, which flags (data1+data2) mod 2^W == 0 for every opcode; it is forwarded unmodified.
//   - The non-owner's response registers never change.
//   - Deasserting valid before ready is legal and has no effect.
//   - The operand inputs are sampled only at the accept edge.
// TESTING
//  1. Reset, then A: op=001, 8'h05, 8'h03 -> a_ready at T0; a_rvalid at T0+1 for one cycle; a_result=8'h08, a_zero=0; b_rvalid stays 0.
//  2. A and B valid together, held:
//     - A: op=010, 8'hF0, 8'h3C. B: op=011, 8'hF0, 8'h0F.
//     - A is served first (a_result=8'h30), then B (b_result=8'hFF); grants alternate A,B,A,B; each response is 3 cycles apart.
//  3. B: op=000, 8'h01, 8'hFF -> b_result=8'hFF, b_zero=1 (1+255 wraps to 0).
//  4. A: op=3'b101 -> a_rvalid next cycle; a_err=1, a_result=0; alu_op keeps its previous value.
//  5. reset_n low during EXEC -> all outputs 0 immediately, no rvalid. After release, A: op=001, 8'h7F, 8'h01 -> a_result=8'h80.
//  6. WAIT_CYC=3: same stimulus as scenario 1 -> a_rvalid at T0+3; a_ready stays low through T0+3.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between requesters A and B.
// Operands are registered toward the ALU; results return with a one-cycle strobe.
module alu_arbiter #(
    parameter int unsigned W        = 8,
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         a_valid,
    output logic         a_ready,
    input  logic [W-1:0] a_data1,
    input  logic [W-1:0] a_data2,
    input  logic [2:0]   a_op,
    output logic         a_rvalid,
    output logic [W-1:0] a_result,
    output logic         a_zero,
    output logic         a_err,
    input  logic         b_valid,
    output logic         b_ready,
    input  logic [W-1:0] b_data1,
    input  logic [W-1:0] b_data2,
    input  logic [2:0]   b_op,
    output logic         b_rvalid,
    output logic [W-1:0] b_result,
    output logic         b_zero,
    output logic         b_err,
    output logic [W-1:0] alu_data1,
    output logic [W-1:0] alu_data2,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_result,
    input  logic         alu_zero
);

    localparam int unsigned CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // owner/last encode the requester: 0 = A, 1 = B
    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  alu_data1_q, alu_data1_d;
    logic [W-1:0]  alu_data2_q, alu_data2_d;
    logic [2:0]    alu_op_q, alu_op_d;
    logic [W-1:0]  a_result_q, a_result_d;
    logic          a_zero_q, a_zero_d;
    logic          a_err_q, a_err_d;
    logic [W-1:0]  b_result_q, b_result_d;
    logic          b_zero_q, b_zero_d;
    logic          b_err_q, b_err_d;

    logic          grant_a, grant_b;
    logic          sel_b;
    logic [W-1:0]  sel_data1, sel_data2;
    logic [2:0]    sel_op;

    always_comb begin
        grant_a   = a_valid && (!b_valid || last_q);
        grant_b   = b_valid && (!a_valid || !last_q);
        a_ready   = (state_q == IDLE) && grant_a;
        b_ready   = (state_q == IDLE) && grant_b;
        sel_b     = b_ready;
        sel_data1 = sel_b ? b_data1 : a_data1;
        sel_data2 = sel_b ? b_data2 : a_data2;
        sel_op    = sel_b ? b_op    : a_op;
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        alu_data1_d = alu_data1_q;
        alu_data2_d = alu_data2_q;
        alu_op_d    = alu_op_q;
        a_result_d  = a_result_q;
        a_zero_d    = a_zero_q;
        a_err_d     = a_err_q;
        b_result_d  = b_result_q;
        b_zero_d    = b_zero_q;
        b_err_d     = b_err_q;
        case (state_q)
            IDLE: begin
                if (a_ready || b_ready) begin
                    owner_d = sel_b;
                    last_d  = sel_b;
                    if (!sel_op[2]) begin
                        alu_data1_d = sel_data1;
                        alu_data2_d = sel_data2;
                        alu_op_d    = sel_op;
                        cnt_d       = CW'(WAIT_CYC - 1);
                        state_d     = EXEC;
                    end else begin
                        // Illegal opcode: answer immediately, ALU registers untouched
                        if (sel_b) begin
                            b_result_d = '0;
                            b_zero_d   = 1'b0;
                            b_err_d    = 1'b1;
                        end else begin
                            a_result_d = '0;
                            a_zero_d   = 1'b0;
                            a_err_d    = 1'b1;
                        end
                        state_d = RESP;
                    end
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    if (owner_q) begin
                        b_result_d = alu_result;
                        b_zero_d   = alu_zero;
                        b_err_d    = 1'b0;
                    end else begin
                        a_result_d = alu_result;
                        a_zero_d   = alu_zero;
                        a_err_d    = 1'b0;
                    end
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            alu_data1_q <= '0;
            alu_data2_q <= '0;
            alu_op_q    <= '0;
            a_result_q  <= '0;
            a_zero_q    <= 1'b0;
            a_err_q     <= 1'b0;
            b_result_q  <= '0;
            b_zero_q    <= 1'b0;
            b_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            alu_data1_q <= alu_data1_d;
            alu_data2_q <= alu_data2_d;
            alu_op_q    <= alu_op_d;
            a_result_q  <= a_result_d;
            a_zero_q    <= a_zero_d;
            a_err_q     <= a_err_d;
            b_result_q  <= b_result_d;
            b_zero_q    <= b_zero_d;
            b_err_q     <= b_err_d;
        end
    end

    assign a_rvalid  = (state_q == RESP) && !owner_q;
    assign b_rvalid  = (state_q == RESP) && owner_q;
    assign a_result  = a_result_q;
    assign a_zero    = a_zero_q;
    assign a_err     = a_err_q;
    assign b_result  = b_result_q;
    assign b_zero    = b_zero_q;
    assign b_err     = b_err_q;
    assign alu_data1 = alu_data1_q;
    assign alu_data2 = alu_data2_q;
    assign alu_op    = alu_op_q;

endmodule
